// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX/RX pair.
//   rx_state_t           : receiver FSM state encoding
//   DATA_BITS            : payload bits per frame (8N1)
//   CLKS_PER_BIT_DEFAULT : default bit period in clk cycles, common to uart_tx and uart_rx
package uart_pkg;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input, reset to 1 (idle-high lines).
//   clk      : destination clock, rising edge
//   reset    : asynchronous, active-low reset
//   async_in : asynchronous input
//   sync_out : input retimed into the clk domain (two-cycle delay)
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta     <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Samples each bit at mid-bit using a cycle counter.
//   clk          : system clock, rising edge
//   reset        : asynchronous, active-low reset
//   rx_in        : serial line, asynchronous, idle high
//   rx_data      : last correctly framed byte, held until the next good frame
//   rx_valid     : one-cycle pulse, rx_data is new in the same cycle
//   rx_frame_err : one-cycle pulse when the stop bit samples 0
//   rx_busy      : high whenever the FSM is not in IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;

  rx_state_t            state, state_d;
  logic                 rx_sync;
  logic [15:0]          cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;

  logic half_tick, bit_tick, last_bit;
  logic shift_en, frame_ok, frame_bad;

  uart_rx_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (rx_in),
    .sync_out (rx_sync)
  );

  assign half_tick = (cnt == 16'(HALF_BIT - 1));
  assign bit_tick  = (cnt == 16'(CLKS_PER_BIT - 1));
  assign last_bit  = (bit_idx == 3'(DATA_BITS - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:      if (!rx_sync) state_d = START;
      // A start bit that has gone high again by mid-bit is treated as a glitch.
      START:     if (half_tick) state_d = rx_sync ? IDLE : DATA;
      DATA:      if (bit_tick && last_bit) state_d = STOP;
      STOP:      if (bit_tick) state_d = rx_sync ? IDLE : WAIT_IDLE;
      // Hold off on a break so the low line is not taken as a new start bit.
      WAIT_IDLE: if (rx_sync) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    shift_en  = (state == DATA) && bit_tick;
    frame_ok  = (state == STOP) && bit_tick && rx_sync;
    frame_bad = (state == STOP) && bit_tick && !rx_sync;
    rx_busy   = (state != IDLE);
  end

  // Datapath: counters, shift register and registered output strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (state_d != state || shift_en) cnt <= '0;
      else if (state != IDLE && state != WAIT_IDLE) cnt <= cnt + 16'd1;

      if (state == IDLE) bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;

      if (shift_en) shift[bit_idx] <= rx_sync;

      if (frame_ok) rx_data <= shift;
      rx_valid     <= frame_ok;
      rx_frame_err <= frame_bad;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: reset, single frame latency, framing error and
// recovery, loopback-style frame, glitch reject, back-to-back frames, reset mid-frame.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;

  int         cyc = 0;
  int         vq[$];
  logic [7:0] dq[$];
  int         ferr_n = 0;
  int         both_n = 0;
  int         wide_n = 0;
  logic       prev_v = 1'b0;
  logic       prev_f = 1'b0;
  int         t0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_in        (rx_in),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      vq.push_back(cyc);
      dq.push_back(rx_data);
    end
    if (rx_frame_err) ferr_n++;
    if (rx_valid && rx_frame_err) both_n++;
    if ((rx_valid && prev_v) || (rx_frame_err && prev_f)) wide_n++;
    prev_v = rx_valid;
    prev_f = rx_frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called aligned at posedge+1; returns aligned at posedge+1.
  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    t0 = cyc + 1;  // index of the edge that first captures the start bit
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  initial begin
    logic [7:0] v55;
    rx_in = 1'b1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data",  32'(rx_data), 32'h00);
    check("reset_valid", 32'(rx_valid), 32'h0);
    check("reset_ferr",  32'(rx_frame_err), 32'h0);
    check("reset_busy",  32'(rx_busy), 32'h0);

    reset = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("idle_no_valid", 32'(vq.size()), 32'd0);
    check("idle_no_ferr",  32'(ferr_n), 32'd0);
    check("idle_busy",     32'(rx_busy), 32'h0);

    // Single frame 0xA5
    send_frame(8'hA5, 1'b1);
    check("a5_count",   32'(vq.size()), 32'd1);
    check("a5_latency", 32'(vq[0] - t0), 32'd154);
    check("a5_pulse",   32'(dq[0]), 32'hA5);
    check("a5_data",    32'(rx_data), 32'hA5);
    check("a5_busy",    32'(rx_busy), 32'h0);
    repeat (5) @(posedge clk);
    #1;

    // Framing error, then a held break
    send_frame(8'h3C, 1'b0);
    rx_in = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("fe_ferr_count", 32'(ferr_n), 32'd1);
    check("fe_no_valid",   32'(vq.size()), 32'd1);
    check("fe_data_held",  32'(rx_data), 32'hA5);
    check("fe_busy_break", 32'(rx_busy), 32'h1);
    rx_in = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("fe_busy_idle",  32'(rx_busy), 32'h0);
    check("fe_no_restart", 32'(ferr_n + vq.size()), 32'd2);

    // Recovery frame
    send_frame(8'h0F, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("rec_count", 32'(vq.size()), 32'd2);
    check("rec_pulse", 32'(dq[1]), 32'h0F);
    check("rec_data",  32'(rx_data), 32'h0F);

    // Frame serialised exactly as uart_tx sends 0xAA
    send_frame(8'hAA, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("lb_count", 32'(vq.size()), 32'd3);
    check("lb_pulse", 32'(dq[2]), 32'hAA);
    check("lb_ferr",  32'(ferr_n), 32'd1);

    // 3-cycle glitch
    rx_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("gl_no_valid", 32'(vq.size()), 32'd3);
    check("gl_no_ferr",  32'(ferr_n), 32'd1);
    check("gl_busy",     32'(rx_busy), 32'h0);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("b2b_count",   32'(vq.size()), 32'd5);
    check("b2b_first",   32'(dq[3]), 32'h00);
    check("b2b_second",  32'(dq[4]), 32'hFF);
    check("b2b_spacing", 32'(vq[4] - vq[3]), 32'd160);

    // Reset during data bit 4 of 0x55
    v55 = 8'h55;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(v55[i]);
    rx_in = v55[4];
    repeat (8) @(posedge clk);
    #1;
    check("mid_busy", 32'(rx_busy), 32'h1);
    reset = 1'b0;
    #1;
    check("mid_rst_data",  32'(rx_data), 32'h00);
    check("mid_rst_busy",  32'(rx_busy), 32'h0);
    check("mid_rst_valid", 32'(rx_valid), 32'h0);
    check("mid_rst_ferr",  32'(rx_frame_err), 32'h0);
    rx_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send_frame(8'h81, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("post_count", 32'(vq.size()), 32'd6);
    check("post_pulse", 32'(dq[5]), 32'h81);
    check("post_data",  32'(rx_data), 32'h81);
    check("post_ferr",  32'(ferr_n), 32'd1);

    check("never_both",  32'(both_n), 32'd0);
    check("single_wide", 32'(wide_n), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
